// File: rtl/fir_coef_ctrl.sv
// Coefficient bank controller for a 4-tap FIR: shadow/active coefficient sets,
// with a commit that drains in-flight samples before swapping the active set.
module fir_coef_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int PIPE_LAT   = 3,
  parameter int CNT_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_wr_en,
  input  logic [1:0]                   cfg_wr_addr,
  input  logic [DATA_WIDTH-1:0]        cfg_wr_data,
  input  logic                         cfg_commit,
  output logic                         cfg_busy,
  output logic                         commit_done,
  input  logic                         s_valid,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  output logic                         s_ready,
  output logic                         fir_valid_in,
  output logic signed [DATA_WIDTH-1:0] fir_data_in,
  input  logic                         fir_valid_out,
  output logic signed [DATA_WIDTH-1:0] h0,
  output logic signed [DATA_WIDTH-1:0] h1,
  output logic signed [DATA_WIDTH-1:0] h2,
  output logic signed [DATA_WIDTH-1:0] h3,
  output logic                         err_underflow
);

  // The counter must be able to hold every sample the FIR can have in flight.
  if ((1 << CNT_W) <= PIPE_LAT) begin : g_bad_cnt_w
    $error("fir_coef_ctrl: CNT_W too small for PIPE_LAT");
  end

  // 0.25 in Q1.15 (scaled to DATA_WIDTH): a 4-tap moving average.
  localparam logic [DATA_WIDTH-1:0] COEF_RST = {3'b001, {(DATA_WIDTH-3){1'b0}}};
  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]      CNT_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_WIDTH-1:0]   shadow [4];
  logic                    cnt_inc, cnt_dec;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    cfg_busy    = 1'b1;
    commit_done = 1'b0;
    case (state)
      ST_RUN: begin
        s_ready  = 1'b1;
        cfg_busy = 1'b0;
        if (cfg_commit) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Registered count plus the live fir_valid_out: the last sample must
        // have both left the counter and not be emerging this very cycle.
        if ((cnt == CNT_ZERO) && !fir_valid_out) state_nxt = ST_SWAP;
      end
      ST_SWAP: begin
        commit_done = 1'b1;
        state_nxt   = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  assign fir_valid_in = s_valid & s_ready;
  assign fir_data_in  = s_data;

  assign cnt_inc = fir_valid_in & ~fir_valid_out;
  assign cnt_dec = fir_valid_out & ~fir_valid_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= CNT_ZERO;
    end else if (cnt_inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end else if (cnt_dec && (cnt != CNT_ZERO)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                  err_underflow <= 1'b0;
    else if (cnt_dec && (cnt == CNT_ZERO))    err_underflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) shadow[i] <= COEF_RST;
    end else if (cfg_wr_en) begin
      shadow[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  // Active set samples the shadow as it stood before any same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      h0 <= COEF_RST;
      h1 <= COEF_RST;
      h2 <= COEF_RST;
      h3 <= COEF_RST;
    end else if (state == ST_SWAP) begin
      h0 <= shadow[0];
      h1 <= shadow[1];
      h2 <= shadow[2];
      h3 <= shadow[3];
    end
  end

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed bench for fir_coef_ctrl: vector table for the basic commit flow,
// hand sequences for drain, swap-write, saturation, underflow and reset cases.
module tb_fir_coef_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_wr_en;
  logic [1:0]         cfg_wr_addr;
  logic [15:0]        cfg_wr_data;
  logic               cfg_commit;
  logic               cfg_busy;
  logic               commit_done;
  logic               s_valid;
  logic signed [15:0] s_data;
  logic               s_ready;
  logic               fir_valid_in;
  logic signed [15:0] fir_data_in;
  logic               fir_valid_out;
  logic signed [15:0] h0, h1, h2, h3;
  logic               err_underflow;

  logic               auto_fir;
  logic               fvo_man;
  logic [2:0]         pipe;

  int checks = 0;
  int failures = 0;

  fir_coef_ctrl #(.DATA_WIDTH(16), .PIPE_LAT(3), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .commit_done(commit_done),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .fir_valid_in(fir_valid_in), .fir_data_in(fir_data_in),
    .fir_valid_out(fir_valid_out),
    .h0(h0), .h1(h1), .h2(h2), .h3(h3),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Simple FIR stand-in: valid_out follows valid_in by three cycles.
  always @(posedge clk) begin
    if (rst) pipe <= 3'b000;
    else     pipe <= {pipe[1:0], fir_valid_in};
  end
  assign fir_valid_out = auto_fir ? pipe[2] : fvo_man;

  typedef struct {
    logic        s_valid;
    logic [15:0] s_data;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        commit;
    logic        exp_ready;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_fvi;
  } vec_t;

  vec_t vecs [11];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs;
    cfg_wr_en   = 1'b0;
    cfg_wr_addr = 2'd0;
    cfg_wr_data = 16'h0000;
    cfg_commit  = 1'b0;
    s_valid     = 1'b0;
    s_data      = 16'sh0000;
    fvo_man     = 1'b0;
  endtask

  task automatic chk_h(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                       input logic [15:0] e2, input logic [15:0] e3);
    chk({tag, "_h0"}, h0, e0);
    chk({tag, "_h1"}, h1, e1);
    chk({tag, "_h2"}, h2, e2);
    chk({tag, "_h3"}, h3, e3);
  endtask

  task automatic idle_commit(input string tag);
    cfg_commit = 1'b1;
    settle();
    chk({tag, "_c0_busy"}, {15'd0, cfg_busy}, 16'd0);
    tick();
    cfg_commit = 1'b0;
    settle();
    chk({tag, "_c1_done"}, {15'd0, commit_done}, 16'd0);
    tick();
    settle();
    chk({tag, "_c2_done"}, {15'd0, commit_done}, 16'd1);
    tick();
  endtask

  initial begin
    //          sv  data      we  a   wdata    cm  rdy bsy dn  fvi
    vecs[0]  = '{1'b1, 16'h1234, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 16'h7fff, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 16'h8001, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 16'h5555, 1'b1, 2'd0, 16'h4000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 16'h0000, 1'b1, 2'd1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 1'b1, 2'd2, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 16'h0000, 1'b1, 2'd3, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 16'habcd, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 16'h1111, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    idle_inputs();
    auto_fir = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk_h("rst", 16'h2000, 16'h2000, 16'h2000, 16'h2000);
    chk("rst_ready", {15'd0, s_ready}, 16'd1);
    chk("rst_busy",  {15'd0, cfg_busy}, 16'd0);
    chk("rst_err",   {15'd0, err_underflow}, 16'd0);
    chk("rst_done",  {15'd0, commit_done}, 16'd0);
    tick();

    // Pass-through, shadow writes, then an idle commit with traffic offered in DRAIN/SWAP.
    auto_fir = 1'b1;
    for (int i = 0; i < 11; i++) begin
      s_valid     = vecs[i].s_valid;
      s_data      = vecs[i].s_data;
      cfg_wr_en   = vecs[i].wr_en;
      cfg_wr_addr = vecs[i].wr_addr;
      cfg_wr_data = vecs[i].wr_data;
      cfg_commit  = vecs[i].commit;
      settle();
      chk($sformatf("vec%0d_ready", i), {15'd0, s_ready}, {15'd0, vecs[i].exp_ready});
      chk($sformatf("vec%0d_busy", i),  {15'd0, cfg_busy}, {15'd0, vecs[i].exp_busy});
      chk($sformatf("vec%0d_done", i),  {15'd0, commit_done}, {15'd0, vecs[i].exp_done});
      chk($sformatf("vec%0d_fvi", i),   {15'd0, fir_valid_in}, {15'd0, vecs[i].exp_fvi});
      chk($sformatf("vec%0d_data", i),  fir_data_in, vecs[i].s_data);
      tick();
    end
    idle_inputs();
    settle();
    chk_h("idle_commit", 16'h4000, 16'h0000, 16'h0000, 16'h0000);
    tick();

    // Drain with three samples in flight; a commit offered mid-DRAIN is dropped.
    begin
      logic [9:0] sv  = 10'b0011111111;
      logic [9:0] cm  = 10'b0000010100;
      logic [9:0] rdy = 10'b1100000111;
      logic [9:0] bsy = 10'b0011111000;
      logic [9:0] dn  = 10'b0010000000;
      logic [9:0] fvi = 10'b0000000111;
      for (int c = 0; c < 10; c++) begin
        s_valid    = sv[c];
        s_data     = 16'(16'h0100 + c);
        cfg_commit = cm[c];
        settle();
        chk($sformatf("drain_c%0d_ready", c), {15'd0, s_ready}, {15'd0, rdy[c]});
        chk($sformatf("drain_c%0d_busy", c),  {15'd0, cfg_busy}, {15'd0, bsy[c]});
        chk($sformatf("drain_c%0d_done", c),  {15'd0, commit_done}, {15'd0, dn[c]});
        chk($sformatf("drain_c%0d_fvi", c),   {15'd0, fir_valid_in}, {15'd0, fvi[c]});
        tick();
      end
      idle_inputs();
    end

    // Shadow write landing in the SWAP cycle.
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    cfg_wr_en = 1'b1; cfg_wr_addr = 2'd1; cfg_wr_data = 16'h1000;
    settle();
    chk("swapwr_done", {15'd0, commit_done}, 16'd1);
    tick();
    idle_inputs();
    settle();
    chk_h("swapwr_first", 16'h4000, 16'h0000, 16'h0000, 16'h0000);
    tick();
    idle_commit("swapwr2");
    settle();
    chk_h("swapwr_second", 16'h4000, 16'h1000, 16'h0000, 16'h0000);

    // Counter saturation: nine samples, seven FIR outputs empty the counter.
    auto_fir = 1'b0;
    for (int k = 0; k < 9; k++) begin
      s_valid    = 1'b1;
      s_data     = 16'(k);
      cfg_commit = (k == 8);
      tick();
    end
    idle_inputs();
    fvo_man = 1'b1;
    for (int k = 0; k < 7; k++) begin
      settle();
      chk($sformatf("sat_p%0d_done", k), {15'd0, commit_done}, 16'd0);
      tick();
    end
    fvo_man = 1'b0;
    settle();
    chk("sat_last_drain_busy", {15'd0, cfg_busy}, 16'd1);
    chk("sat_last_drain_done", {15'd0, commit_done}, 16'd0);
    tick();
    settle();
    chk("sat_swap_done", {15'd0, commit_done}, 16'd1);
    chk("sat_err", {15'd0, err_underflow}, 16'd0);
    tick();

    // Underflow: simultaneous in/out at zero is not an error; a bare output is.
    s_valid = 1'b1;
    fvo_man = 1'b1;
    tick();
    s_valid = 1'b0;
    settle();
    chk("uf_both_err", {15'd0, err_underflow}, 16'd0);
    tick();
    fvo_man = 1'b0;
    settle();
    chk("uf_set", {15'd0, err_underflow}, 16'd1);
    for (int k = 0; k < 3; k++) tick();
    settle();
    chk("uf_sticky", {15'd0, err_underflow}, 16'd1);

    // Reset in the middle of a drain abandons the commit and restores defaults.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("rst2_err", {15'd0, err_underflow}, 16'd0);
    cfg_wr_en = 1'b1; cfg_wr_addr = 2'd0; cfg_wr_data = 16'h7000;
    tick();
    idle_inputs();
    s_valid = 1'b1;
    tick();
    cfg_commit = 1'b1;
    tick();
    idle_inputs();
    settle();
    chk("mid_drain_busy", {15'd0, cfg_busy}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("mid_rst_busy",  {15'd0, cfg_busy}, 16'd0);
    chk("mid_rst_ready", {15'd0, s_ready}, 16'd1);
    chk("mid_rst_done",  {15'd0, commit_done}, 16'd0);
    chk_h("mid_rst", 16'h2000, 16'h2000, 16'h2000, 16'h2000);
    tick();
    settle();
    chk("mid_rst_nodone", {15'd0, commit_done}, 16'd0);
    chk("mid_rst_stays_run", {15'd0, cfg_busy}, 16'd0);
    tick();
    idle_commit("post_rst");
    settle();
    chk_h("post_rst", 16'h2000, 16'h2000, 16'h2000, 16'h2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
